mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing one multi-cycle memory (or memory_cache-style) port between the instruction-fetch stage and the memory stage of the MIPS pipeline. It grants one requester at a time, latches address/write data, sequences the downstream ready handshake and returns per-port read data. It also drives per-port stall lines that freeze the corresponding pipeline stage until its access completes.

## Interface
- `ADDR_W`, default 32: address width of all ports.
- `DATA_W`, default 32: data width of all ports.

- `clock`: in, 1, rising-edge clock.
- `reset`: in, 1, asynchronous, active-high.
- `i_read`: in, 1, fetch read request; held until `i_stall` = 0.
- `i_address`: in, `ADDR_W`, fetch address.
- `i_data`: out, `DATA_W`, fetch read data.
- `i_stall`: out, 1, fetch access pending.
- `d_read`, `d_write`: in, 1 each, data-stage read (LW) and write (SW) requests.
- `d_address`: in, `ADDR_W`, data address (ALU result).
- `d_data_in`: in, `DATA_W`, store data (valB).
- `d_data_out`: out, `DATA_W`, load data.
- `d_stall`: out, 1, data access pending.
- `m_read`, `m_write`: out, 1 each, downstream strobes.
- `m_address`: out, `ADDR_W`, downstream address.
- `m_data_out`: out, `DATA_W`, downstream write data.
- `m_data_in`: in, `DATA_W`, downstream read data.
- `m_ready`: in, 1, downstream completes the current access this cycle.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- Requests: `i_req = i_read`; `d_req = d_read | d_write`. If `d_read` and `d_write` are both 1, the access is a write.
- IDLE:
  - With no request, stay in IDLE.
  - With one request, latch its address and write data (`d_data_in`), plus its type, then go to SERVE_x.
  - With both requests, arbitrate (see Configuration) and leave the loser waiting.
- SERVE_x:
  - `m_read`/`m_write` are asserted from registers, with latched `m_address`/`m_data_out`.
  - On `m_ready` = 1: for a read, capture `m_data_in` into `i_data` or `d_data_out`; then go to RESP_x with the strobes cleared.
  - On `m_ready` = 0: remain in SERVE_x; there is no timeout.
- RESP_x: one cycle; go to IDLE. The requester advances on this clock edge.
- Stall: `x_stall = x_req & ~(state == RESP_x)`, combinational.
  - The losing port stays stalled through the winner's whole transaction.
- Writes leave `d_data_out` unchanged. `i_data`/`d_data_out` hold their value until the next read on that port completes.
- `m_ready` outside SERVE_x is ignored.
- If a request drops during SERVE_x (illegal), the access still completes to memory and RESP_x is still taken; captured data is kept.
- Reset, asynchronous and at any time including mid-transaction:
  - State returns to IDLE.
  - `m_read` = `m_write` = 0 immediately.
  - `m_address`, `m_data_out`, `i_data`, `d_data_out` = 0.
  - Round-robin pointer = last-granted I.
  - Stalls then equal their requests; they are 0 when idle.
  - An in-flight access is abandoned and re-issued after reset if still requested.

## Timing
- Single access with `m_ready` high on the first SERVE cycle:
  - Cycle 0 (IDLE): request seen, `x_stall` = 1.
  - Cycle 1 (SERVE): `m_*` asserted, `x_stall` = 1.
  - Cycle 2 (RESP): data valid, `x_stall` = 0.
- Minimum latency is 3 cycles, i.e. 2 stall cycles. Each extra `m_ready` = 0 cycle adds one stall cycle.
- Back-to-back accesses from one port: the new request is sampled in IDLE the cycle after RESP, so 3 cycles per access.
- Contention: the loser enters SERVE in the cycle after the winner's RESP→IDLE cycle. Its earliest completion is RESP at cycle 5 from a shared cycle-0 request.
- All outputs except the stalls are registered.

## Configuration
- `MEM_ARB_RR_EN` undefined: fixed priority; D (the older instruction) wins every contention.
- `MEM_ARB_RR_EN` defined: a 1-bit last-grant register, updated on every grant. On contention the port not granted last wins; after reset, first contention goes to D. Non-contended grants also update the pointer.

## Test plan
- Fetch only: `i_read` = 1, `i_address` = 0x40, memory returns 0x8C220004 with `m_ready` = 1 in cycle 1.
  - Required: `m_read` = 1 and `m_address` = 0x40 in cycle 1.
  - Required: `i_data` = 0x8C220004 and `i_stall` = 0 in cycle 2.
  - Required: `i_stall` = 1 in cycles 0–1.
- Store with 3-cycle memory: `d_write` = 1, `d_address` = 0x100, `d_data_in` = 0xDEADBEEF, `m_ready` = 1 on the third SERVE cycle.
  - Required: `m_write` held for 3 cycles with stable address/data.
  - Required: `d_stall` = 1 for 4 cycles, then 0.
  - Required: `d_data_out` unchanged.
- Contention, fixed priority: `i_read` and `d_read` asserted together in cycle 0, 1-cycle memory.
  - Required: D served first (RESP_D in cycle 2).
  - Required: I served next (RESP_I in cycle 5); `i_stall` = 1 in cycles 0–4.
- Contention with `MEM_ARB_RR_EN`: two consecutive contentions.
  - Required: grants go D, I, D, I.
  - Required: without the macro, every contention grants D first.
- Reset mid-SERVE_D: assert `reset` in cycle 1.
  - Required: `m_write` falls immediately; all data outputs = 0.
  - Required: after reset release, the still-held request is re-issued from IDLE.
- Simultaneous `d_read` = `d_write` = 1: required `m_write` = 1, `m_read` = 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between MIPS fetch (I) and memory (D) stages.
// Latency: 3 cycles minimum (IDLE -> SERVE -> RESP); each m_ready=0 cycle in SERVE adds one.
// Backpressure: i_stall/d_stall hold the requesting stage until its RESP cycle; MEM_ARB_RR_EN selects round-robin over fixed D priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_data,
    output logic              i_stall,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_data_in,
    output logic [DATA_W-1:0] d_data_out,
    output logic              d_stall,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_data_out,
    input  logic [DATA_W-1:0] m_data_in,
    input  logic              m_ready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_i_req;
    logic                w_d_req;
    logic                w_pick_d;
    logic                w_load;
    logic                w_done;
    logic                r_m_read;
    logic                r_m_write;
    logic [ADDR_W-1:0]   r_m_address;
    logic [DATA_W-1:0]   r_m_data_out;
    logic [DATA_W-1:0]   r_i_data;
    logic [DATA_W-1:0]   r_d_data_out;

`ifdef MEM_ARB_RR_EN
    // 1 = D was granted last; reset value points at I so the first contention goes to D.
    logic                r_last_d;

    // Remember which port took the most recent grant, contended or not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (w_load) begin
            r_last_d <= w_pick_d;
        end
    end
`endif

    // Request decode and arbitration: D wins unless round-robin says I is owed the port.
    always_comb begin
        w_i_req = i_read;
        w_d_req = d_read | d_write;
`ifdef MEM_ARB_RR_EN
        w_pick_d = w_d_req & (~w_i_req | ~r_last_d);
`else
        w_pick_d = w_d_req;
`endif
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus the grant (load) and completion (done) strobes.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req | w_d_req) begin
                    w_load = 1'b1;
                    w_next = w_pick_d ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                if (m_ready) begin
                    w_done = 1'b1;
                    w_next = RESP_I;
                end
            end
            SERVE_D: begin
                if (m_ready) begin
                    w_done = 1'b1;
                    w_next = RESP_D;
                end
            end
            RESP_I:  w_next = IDLE;
            RESP_D:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Downstream strobes/address/data latched at grant; read data captured on completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_m_read     <= 1'b0;
            r_m_write    <= 1'b0;
            r_m_address  <= '0;
            r_m_data_out <= '0;
            r_i_data     <= '0;
            r_d_data_out <= '0;
        end else if (w_load) begin
            // A simultaneous d_read/d_write is treated as a store.
            r_m_read    <= w_pick_d ? ~d_write : 1'b1;
            r_m_write   <= w_pick_d & d_write;
            r_m_address <= w_pick_d ? d_address : i_address;
            if (w_pick_d) begin
                r_m_data_out <= d_data_in;
            end
        end else if (w_done) begin
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            // Stores leave the load-data register untouched.
            if (r_m_read) begin
                if (r_state == SERVE_I) begin
                    r_i_data <= m_data_in;
                end else begin
                    r_d_data_out <= m_data_in;
                end
            end
        end
    end

    assign m_read     = r_m_read;
    assign m_write    = r_m_write;
    assign m_address  = r_m_address;
    assign m_data_out = r_m_data_out;
    assign i_data     = r_i_data;
    assign d_data_out = r_d_data_out;

    // Stalls are combinational so a new request freezes its stage in the same cycle.
    assign i_stall = w_i_req & (r_state != RESP_I);
    assign d_stall = w_d_req & (r_state != RESP_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a transaction-level reference model.
// Latency: outputs compared every negedge against the model; literal checks pin key cycles.
// Backpressure: m_ready is driven per cycle by the stimulus to stretch SERVE phases.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_data;
    logic        i_stall;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_data_in;
    logic [31:0] d_data_out;
    logic        d_stall;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_address;
    logic [31:0] m_data_out;
    logic [31:0] m_data_in;
    logic        m_ready;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_read     (i_read),
        .i_address  (i_address),
        .i_data     (i_data),
        .i_stall    (i_stall),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_data_in  (d_data_in),
        .d_data_out (d_data_out),
        .d_stall    (d_stall),
        .m_read     (m_read),
        .m_write    (m_write),
        .m_address  (m_address),
        .m_data_out (m_data_out),
        .m_data_in  (m_data_in),
        .m_ready    (m_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: one fixed instruction word, everything else derived from the address.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C22_0004 : (a ^ 32'hA5A5_0000);
    endfunction

    assign m_data_in = mem_rd(m_address);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // owner: 0 none, 1 fetch, 2 data; in_resp marks the single completion cycle.
    int          owner   = 0;
    bit          in_resp = 1'b0;
    bit          e_rd    = 1'b0;
    bit          e_wr    = 1'b0;
    logic [31:0] e_addr  = '0;
    logic [31:0] e_wdat  = '0;
    logic [31:0] e_idat  = '0;
    logic [31:0] e_ddat  = '0;
    bit          last_d  = 1'b0;
    bit          want_i;
    bit          want_d;
    bit          give_d;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            owner = 0; in_resp = 0; e_rd = 0; e_wr = 0;
            e_addr = '0; e_wdat = '0; e_idat = '0; e_ddat = '0;
            last_d = 0;
        end else if (owner == 0) begin
            want_i = i_read;
            want_d = d_read | d_write;
`ifdef MEM_ARB_RR_EN
            give_d = want_d && !(want_i && last_d);
`else
            give_d = want_d;
`endif
            if (want_i || want_d) begin
                owner  = give_d ? 2 : 1;
                last_d = give_d;
                e_wr   = give_d && d_write;
                e_rd   = !e_wr;
                e_addr = give_d ? d_address : i_address;
                if (give_d) e_wdat = d_data_in;
            end
        end else if (!in_resp) begin
            if (m_ready) begin
                if (e_rd) begin
                    if (owner == 1) e_idat = mem_rd(e_addr);
                    else            e_ddat = mem_rd(e_addr);
                end
                e_rd = 0;
                e_wr = 0;
                in_resp = 1;
            end
        end else begin
            owner   = 0;
            in_resp = 0;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clock) begin
        chk("m_read",     m_read,     e_rd);
        chk("m_write",    m_write,    e_wr);
        chk("m_address",  m_address,  e_addr);
        chk("m_data_out", m_data_out, e_wdat);
        chk("i_data",     i_data,     e_idat);
        chk("d_data_out", d_data_out, e_ddat);
        chk("i_stall",    i_stall,    i_read && !(owner == 1 && in_resp));
        chk("d_stall",    d_stall,    (d_read || d_write) && !(owner == 2 && in_resp));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Both ports request in cycle 0 with single-cycle memory; d_first names the expected winner.
    task automatic contend(input bit d_first);
        tick();
        i_read = 1; i_address = 32'h80;
        d_read = 1; d_write = 0; d_address = 32'h200; m_ready = 1;
        #1 chk("ct_c0_istall", i_stall, 1'b1);
        chk("ct_c0_dstall", d_stall, 1'b1);
        tick();
        #1 chk("ct_c1_addr", m_address, d_first ? 32'h200 : 32'h80);
        chk("ct_c1_mread", m_read, 1'b1);
        tick();
        if (d_first) begin
            #1 chk("ct_c2_dstall", d_stall, 1'b0);
            chk("ct_c2_istall", i_stall, 1'b1);
            chk("ct_c2_ddata", d_data_out, 32'hA5A5_0200);
        end else begin
            #1 chk("ct_c2_istall", i_stall, 1'b0);
            chk("ct_c2_dstall", d_stall, 1'b1);
            chk("ct_c2_idata", i_data, 32'hA5A5_0080);
        end
        tick();
        if (d_first) d_read = 0; else i_read = 0;
        #1 chk("ct_c3_loser_stall", d_first ? i_stall : d_stall, 1'b1);
        tick();
        #1 chk("ct_c4_addr", m_address, d_first ? 32'h80 : 32'h200);
        chk("ct_c4_loser_stall", d_first ? i_stall : d_stall, 1'b1);
        tick();
        #1 chk("ct_c5_loser_stall", d_first ? i_stall : d_stall, 1'b0);
        tick();
        i_read = 0; d_read = 0; m_ready = 0;
    endtask

    initial begin
        reset = 1; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
        d_address = 0; d_data_in = 0; m_ready = 0;
        repeat (2) tick();
        #1 chk("rst_mread", m_read, 1'b0);
        chk("rst_idata", i_data, 32'h0);
        chk("rst_istall", i_stall, 1'b0);
        reset = 0;

        // Fetch only, memory ready on the first SERVE cycle.
        tick();
        i_read = 1; i_address = 32'h40; m_ready = 1;
        #1 chk("f_c0_istall", i_stall, 1'b1);
        tick();
        #1 chk("f_c1_mread", m_read, 1'b1);
        chk("f_c1_addr", m_address, 32'h40);
        chk("f_c1_istall", i_stall, 1'b1);
        tick();
        #1 chk("f_c2_idata", i_data, 32'h8C22_0004);
        chk("f_c2_istall", i_stall, 1'b0);
        tick();
        i_read = 0; m_ready = 0;

        // First contention: last grant was I, so D wins in both builds.
        contend(1'b1);

        // Store with a 3-cycle memory.
        tick();
        d_write = 1; d_address = 32'h100; d_data_in = 32'hDEAD_BEEF; m_ready = 0;
        #1 chk("s_c0_dstall", d_stall, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) m_ready = 1;
            #1 chk("s_mwrite", m_write, 1'b1);
            chk("s_addr", m_address, 32'h100);
            chk("s_wdata", m_data_out, 32'hDEAD_BEEF);
            chk("s_dstall", d_stall, 1'b1);
        end
        tick();
        #1 chk("s_c4_dstall", d_stall, 1'b0);
        chk("s_c4_mwrite", m_write, 1'b0);
        chk("s_ddata_kept", d_data_out, 32'hA5A5_0200);
        tick();
        d_write = 0; m_ready = 0;

        // Contention right after a D grant: round-robin hands it to I.
`ifdef MEM_ARB_RR_EN
        contend(1'b0);
`else
        contend(1'b1);
`endif

        // d_read and d_write together behave as a store.
        tick();
        d_read = 1; d_write = 1; d_address = 32'h400; d_data_in = 32'h55; m_ready = 1;
        tick();
        #1 chk("rw_mwrite", m_write, 1'b1);
        chk("rw_mread", m_read, 1'b0);
        chk("rw_wdata", m_data_out, 32'h55);
        tick();
        #1 chk("rw_dstall", d_stall, 1'b0);
        chk("rw_ddata_kept", d_data_out, 32'hA5A5_0200);
        tick();
        d_read = 0; d_write = 0; m_ready = 0;

        // Reset in the middle of a store; the held request is reissued.
        tick();
        d_write = 1; d_address = 32'h300; d_data_in = 32'h1234_5678; m_ready = 0;
        tick();
        #1 chk("rm_c1_mwrite", m_write, 1'b1);
        reset = 1;
        #1 chk("rm_mwrite_drop", m_write, 1'b0);
        chk("rm_addr", m_address, 32'h0);
        chk("rm_wdata", m_data_out, 32'h0);
        chk("rm_idata", i_data, 32'h0);
        chk("rm_ddata", d_data_out, 32'h0);
        chk("rm_dstall", d_stall, 1'b1);
        tick();
        reset = 0;
        tick();
        #1 chk("rm_reissue_mwrite", m_write, 1'b1);
        chk("rm_reissue_addr", m_address, 32'h300);
        m_ready = 1;
        tick();
        #1 chk("rm_resp_dstall", d_stall, 1'b0);
        tick();
        d_write = 0; m_ready = 0;

        // Fresh reset, then two contentions: grants D, I, D, I.
        tick();
        reset = 1;
        tick();
        reset = 0;
        contend(1'b1);
        contend(1'b1);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
